sdc_cmd_arbiter: RTL and testbench
==================================

Name: sdc_cmd_arbiter

Overview:
- wb_clk-domain scheduler that shares the SD command path between two requesters: 0 = software register file, 1 = block/DMA engine.
- Arbitrates round-robin and programs the SD clock divider per command, waiting a settle time after any change.
- Issues a one-cycle command-start pulse, then waits for completion or timeout.
- Sequences soft reset of the SD clock domain on timeout or abort.

Parameters:
- DIV_BITS, 8, width of the divider value.
- ARG_W, 32, command argument width.
- INIT_DIV, 255, divider value driven out of reset (slowest clock, init mode).
- SETTLE_CYCLES, 16, wb_clk cycles to wait after a divider change before issuing.
- TIMEOUT_W, 20, width of the completion-timeout counter; timeout fires at all-ones.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- req_valid  in  2  per-requester command request
- req_ready  out  2  one-hot grant/accept, single-cycle
- req_cmd0, req_cmd1  in  6  command index per requester
- req_arg0, req_arg1  in  ARG_W  argument per requester
- req_div0, req_div1  in  DIV_BITS  required divider per requester
- abort  in  1  software abort/soft-reset request, single-cycle pulse
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  1  requester the response belongs to
- rsp_status  out  2  0 = ok, 1 = timeout, 2 = aborted
- cmd_index  out  6  held-stable command index to the SD domain
- cmd_arg  out  ARG_W  held-stable argument to the SD domain
- clkdiv_value  out  DIV_BITS  divider to the clocking block
- cmd_start  out  1  one-cycle start pulse, toggle-synchronized downstream
- soft_rst  out  1  one-cycle soft-reset pulse
- soft_rst_status  in  1  SD-domain reset status, already in wb_clk, high while SD side is in reset
- done_tgl  in  1  SD-side completion toggle, already registered into wb_clk
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - FSM = RST_RELEASE; clkdiv_value = INIT_DIV.
  - cmd_index = 0, cmd_arg = 0.
  - cmd_start, soft_rst, rsp_valid, req_ready = 0; rsp_id = 0, rsp_status = 0.
  - rr pointer = 0 (requester 0 has priority first); busy = 1.
- RST_ASSERT: wait until soft_rst_status = 1, then go to RST_RELEASE.
- RST_RELEASE:
  - done_q tracks done_tgl every cycle.
  - When soft_rst_status = 0, go to IDLE.
- IDLE, when any req_valid is set:
  - Grant: if both are set, grant the requester other than the last one granted; otherwise grant the single requester.
  - Assert req_ready for the granted requester for this cycle only.
  - Latch its cmd, arg and div into cmd_index, cmd_arg and pend_div; update the rr pointer.
  - If pend_div != clkdiv_value: load clkdiv_value, clear the settle counter, go to DIV_SETTLE. Otherwise go to ISSUE.
- DIV_SETTLE: count to SETTLE_CYCLES-1, then go to ISSUE. Latency from grant to cmd_start is SETTLE_CYCLES+1 cycles.
- ISSUE:
  - cmd_start = 1 for exactly one cycle.
  - Clear the timeout counter; go to WAIT_DONE.
  - Grant-to-cmd_start latency without a divider change is 1 cycle.
- WAIT_DONE:
  - done_tgl != done_q: done_q <= done_tgl; go to RESP with status 0.
  - Else, counter all-ones: soft_rst = 1 for one cycle; go to RESP with status 1; the post-RESP target is RST_ASSERT.
  - Else, increment the counter.
- RESP:
  - rsp_valid = 1 for one cycle, with rsp_id = granted id.
  - Next state is IDLE, or RST_ASSERT after a timeout or abort.
- Stability: cmd_index and cmd_arg are held from grant until the next grant, and never change while busy.
- abort, in any state other than RST_ASSERT or RST_RELEASE:
  - soft_rst pulse on the next cycle.
  - From WAIT_DONE, DIV_SETTLE or ISSUE: go to RESP with status 2, then RST_ASSERT.
  - From IDLE: go directly to RST_ASSERT with no response.
  - abort has priority over completion and timeout arriving in the same cycle.
  - abort during reset states is ignored.
- Simultaneous req_valid and abort in IDLE: abort wins and no grant is given.
- Soft reset does not change clkdiv_value.
- wb_rst mid-command: everything returns to reset values immediately; no response is emitted.

Decomposition:
- Package sdc_pkg holds:
  - FSM state enum;
  - rsp_status codes (SDC_RSP_OK = 0, SDC_RSP_TIMEOUT = 1, SDC_RSP_ABORT = 2);
  - command index width (6).
- One natural sub-module: sdc_rr_arb2, a 2-input round-robin grant with pointer update on accept.

Test Plan:
- Reset:
  - Stimulus: release wb_rst with soft_rst_status = 1, drop it to 0 after 10 cycles.
  - Required response: busy stays 1 until then; clkdiv_value = 255; no cmd_start.
- Same divider:
  - Stimulus: req0 with cmd = 0, arg = 0, div = 255.
  - Required response: req_ready[0] on the grant cycle, cmd_start exactly 1 cycle later; toggling done_tgl gives rsp_valid, rsp_id = 0, rsp_status = 0.
- Divider change:
  - Stimulus: req1 with div = 1.
  - Required response: clkdiv_value = 1 on the cycle after grant; cmd_start 17 cycles after grant.
- Contention:
  - Stimulus: req_valid = 2'b11 continuously, with done returned each time.
  - Required response: grants alternate 0,1,0,1; cmd_arg matches the granted requester each time.
- Timeout (TIMEOUT_W = 4 in the bench):
  - Stimulus: never toggle done_tgl.
  - Required response: soft_rst pulse 16 cycles after cmd_start; rsp_status = 1; busy holds until soft_rst_status goes 1 then 0.
- Abort:
  - Stimulus: abort during WAIT_DONE, with done_tgl toggling in the same cycle.
  - Required response: rsp_status = 2, one soft_rst pulse, FSM enters RST_ASSERT.

Source files
------------

// File: rtl/sdc_pkg.sv
// Shared types for the SD command arbiter: FSM states, response codes, widths.
package sdc_pkg;

  localparam int CMD_W = 6;

  typedef enum logic [2:0] {
    ST_RST_ASSERT,
    ST_RST_RELEASE,
    ST_IDLE,
    ST_DIV_SETTLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP
  } sdc_state_e;

  localparam logic [1:0] SDC_RSP_OK      = 2'd0;
  localparam logic [1:0] SDC_RSP_TIMEOUT = 2'd1;
  localparam logic [1:0] SDC_RSP_ABORT   = 2'd2;

endpackage

// File: rtl/sdc_rr_arb2.sv
// Two-way round-robin grant; the pointer moves only when a grant is accepted.
module sdc_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr;

  // ptr names the requester that wins when both ask
  always_comb begin
    gnt_id = (req == 2'b11) ? ptr : req[1];
    gnt    = '0;
    if (en && (req != 2'b00)) gnt[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          ptr <= 1'b0;
    else if (en && (req != 2'b00))    ptr <= ~gnt_id;
  end

endmodule

// File: rtl/sdc_cmd_arbiter.sv
// Shares the SD command path between the register file and the DMA engine,
// reprograms the SD clock divider per command and sequences SD soft reset.
module sdc_cmd_arbiter
  import sdc_pkg::*;
#(
  parameter int DIV_BITS      = 8,
  parameter int ARG_W         = 32,
  parameter int INIT_DIV      = 255,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 20
) (
  input  logic                wb_clk,
  input  logic                wb_rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [CMD_W-1:0]    req_cmd0,
  input  logic [CMD_W-1:0]    req_cmd1,
  input  logic [ARG_W-1:0]    req_arg0,
  input  logic [ARG_W-1:0]    req_arg1,
  input  logic [DIV_BITS-1:0] req_div0,
  input  logic [DIV_BITS-1:0] req_div1,
  input  logic                abort,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [1:0]          rsp_status,
  output logic [CMD_W-1:0]    cmd_index,
  output logic [ARG_W-1:0]    cmd_arg,
  output logic [DIV_BITS-1:0] clkdiv_value,
  output logic                cmd_start,
  output logic                soft_rst,
  input  logic                soft_rst_status,
  input  logic                done_tgl,
  output logic                busy
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  sdc_state_e          state;
  logic                done_q;
  logic                rst_after;
  logic [SET_W-1:0]    settle_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  logic                arb_en;
  logic                gnt_id;
  logic [CMD_W-1:0]    sel_cmd;
  logic [ARG_W-1:0]    sel_arg;
  logic [DIV_BITS-1:0] sel_div;

  // abort in IDLE suppresses the grant entirely
  assign arb_en = (state == ST_IDLE) && !abort;
  assign busy   = (state != ST_IDLE);

  sdc_rr_arb2 u_arb (
    .clk    (wb_clk),
    .rst    (wb_rst),
    .req    (req_valid),
    .en     (arb_en),
    .gnt    (req_ready),
    .gnt_id (gnt_id)
  );

  assign sel_cmd = gnt_id ? req_cmd1 : req_cmd0;
  assign sel_arg = gnt_id ? req_arg1 : req_arg0;
  assign sel_div = gnt_id ? req_div1 : req_div0;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state        <= ST_RST_RELEASE;
      clkdiv_value <= DIV_BITS'(INIT_DIV);
      cmd_index    <= '0;
      cmd_arg      <= '0;
      cmd_start    <= 1'b0;
      soft_rst     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_status   <= SDC_RSP_OK;
      done_q       <= 1'b0;
      rst_after    <= 1'b0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
    end else begin
      cmd_start <= 1'b0;
      soft_rst  <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        ST_RST_ASSERT: begin
          if (soft_rst_status) state <= ST_RST_RELEASE;
        end
        ST_RST_RELEASE: begin
          done_q <= done_tgl;
          if (!soft_rst_status) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (abort) begin
            soft_rst <= 1'b1;
            state    <= ST_RST_ASSERT;
          end else if (req_valid != 2'b00) begin
            cmd_index <= sel_cmd;
            cmd_arg   <= sel_arg;
            rsp_id    <= gnt_id;
            rst_after <= 1'b0;
            if (sel_div != clkdiv_value) begin
              clkdiv_value <= sel_div;
              settle_cnt   <= '0;
              state        <= ST_DIV_SETTLE;
            end else begin
              cmd_start <= 1'b1;
              tmo_cnt   <= '0;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_DIV_SETTLE: begin
          if (abort) begin
            soft_rst   <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_status <= SDC_RSP_ABORT;
            rst_after  <= 1'b1;
            state      <= ST_RESP;
          end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            cmd_start <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ST_ISSUE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          // timeout counts from the cmd_start cycle itself
          if (abort) begin
            soft_rst   <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_status <= SDC_RSP_ABORT;
            rst_after  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            state   <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (abort) begin
            soft_rst   <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_status <= SDC_RSP_ABORT;
            rst_after  <= 1'b1;
            state      <= ST_RESP;
          end else if (done_tgl != done_q) begin
            done_q     <= done_tgl;
            rsp_valid  <= 1'b1;
            rsp_status <= SDC_RSP_OK;
            state      <= ST_RESP;
          end else if (&tmo_cnt) begin
            soft_rst   <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_status <= SDC_RSP_TIMEOUT;
            rst_after  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (abort) begin
            soft_rst <= 1'b1;
            state    <= ST_RST_ASSERT;
          end else begin
            state <= rst_after ? ST_RST_ASSERT : ST_IDLE;
          end
        end
        default: state <= ST_RST_ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_cmd_arbiter.sv
// Scoreboard bench: stimulus queues expected events/probes, a negedge monitor compares.
module tb_sdc_cmd_arbiter;
  import sdc_pkg::*;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [1:0]  req_valid, req_ready;
  logic [5:0]  req_cmd0, req_cmd1, cmd_index;
  logic [31:0] req_arg0, req_arg1, cmd_arg;
  logic [7:0]  req_div0, req_div1, clkdiv_value;
  logic        abort, rsp_valid, rsp_id, cmd_start, soft_rst;
  logic        soft_rst_status, done_tgl, busy;
  logic [1:0]  rsp_status;

  sdc_cmd_arbiter #(
    .DIV_BITS(8), .ARG_W(32), .INIT_DIV(255), .SETTLE_CYCLES(16), .TIMEOUT_W(4)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .req_arg0(req_arg0), .req_arg1(req_arg1),
    .req_div0(req_div0), .req_div1(req_div1), .abort(abort), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_status(rsp_status), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .clkdiv_value(clkdiv_value), .cmd_start(cmd_start), .soft_rst(soft_rst),
    .soft_rst_status(soft_rst_status), .done_tgl(done_tgl), .busy(busy)
  );

  always #5 wb_clk = ~wb_clk;

  localparam int K_RDY = 0, K_START = 1, K_SRST = 2, K_RSP = 3;
  localparam int P_BUSY = 4, P_DIV = 5, P_IDX = 6, P_ARG = 7;

  typedef struct {
    int          kind;
    int          cyc;
    logic [63:0] data;
  } ev_t;

  ev_t expq[$];
  ev_t probeq[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  end_req = 1'b0;

  always @(posedge wb_clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_RDY:   return "req_ready";
      K_START: return "cmd_start";
      K_SRST:  return "soft_rst";
      K_RSP:   return "rsp";
      P_BUSY:  return "busy";
      P_DIV:   return "clkdiv_value";
      P_IDX:   return "cmd_index";
      P_ARG:   return "cmd_arg";
      default: return "?";
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic observe(input int k, input logic [63:0] d);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected at cycle %0d data=%h", kname(k), cyc, d);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.cyc != cyc || e.data !== d) begin
        failures++;
        $display("FAIL %s: got cycle %0d data=%h, required %s cycle %0d data=%h",
                 kname(k), cyc, d, kname(e.kind), e.cyc, e.data);
      end
    end
  endtask

  function automatic logic [63:0] probe_val(input int k);
    case (k)
      P_BUSY:  return 64'(busy);
      P_DIV:   return 64'(clkdiv_value);
      P_IDX:   return 64'(cmd_index);
      default: return 64'(cmd_arg);
    endcase
  endfunction

  always @(negedge wb_clk) begin
    ev_t p;
    if (req_ready != 2'b00) observe(K_RDY, 64'(req_ready));
    if (cmd_start === 1'b1) observe(K_START, {18'b0, clkdiv_value, cmd_index, cmd_arg});
    if (soft_rst === 1'b1)  observe(K_SRST, 64'd1);
    if (rsp_valid === 1'b1) observe(K_RSP, 64'({rsp_id, rsp_status}));
    while (probeq.size() > 0 && probeq[0].cyc <= cyc) begin
      p = probeq.pop_front();
      checks++;
      if (probe_val(p.kind) !== p.data) begin
        failures++;
        $display("FAIL probe %s at cycle %0d: got %h, required %h",
                 kname(p.kind), cyc, probe_val(p.kind), p.data);
      end
    end
    if (end_req || cyc > 20000) begin
      checks++;
      if (cyc > 20000 || expq.size() != 0 || probeq.size() != 0) begin
        failures++;
        $display("FAIL drain: %0d events and %0d probes outstanding at cycle %0d",
                 expq.size(), probeq.size(), cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic expect_ev(input int k, input int c, input logic [63:0] d);
    expq.push_back('{k, c, d});
  endtask

  task automatic probe(input int k, input logic [63:0] v);
    probeq.push_back('{k, cyc, v});
  endtask

  // a wait that expires leaves a busy probe that is bound to fail
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) probe(P_BUSY, 64'd0);
  endtask

  // lat < 0: no cmd_start is expected for this grant
  task automatic send(input int id, input logic [5:0] cmd, input logic [31:0] arg,
                      input logic [7:0] div, input int lat, output int g);
    wait_idle();
    if (id == 0) begin req_cmd0 = cmd; req_arg0 = arg; req_div0 = div; end
    else         begin req_cmd1 = cmd; req_arg1 = arg; req_div1 = div; end
    req_valid = (id == 0) ? 2'b01 : 2'b10;
    g = cyc;
    expect_ev(K_RDY, g, 64'(req_valid));
    if (lat > 0) expect_ev(K_START, g + lat, {18'b0, div, cmd, arg});
    tick();
    req_valid = 2'b00;
  endtask

  task automatic finish_ok(input int id);
    done_tgl = ~done_tgl;
    expect_ev(K_RSP, cyc + 1, 64'({id[0], SDC_RSP_OK}));
    tick();
  endtask

  task automatic sd_reset_cycle();
    soft_rst_status = 1'b1;
    tick(); tick();
    probe(P_BUSY, 64'd1);
    soft_rst_status = 1'b0;
    wait_idle();
  endtask

  initial begin
    int g, s, id;
    wb_rst = 1'b1; soft_rst_status = 1'b1; done_tgl = 1'b0; abort = 1'b0;
    req_valid = 2'b00; req_cmd0 = '0; req_cmd1 = '0; req_arg0 = '0; req_arg1 = '0;
    req_div0 = '0; req_div1 = '0;
    tick(); tick();
    probe(P_BUSY, 64'd1); probe(P_DIV, 64'd255); probe(P_IDX, 64'd0); probe(P_ARG, 64'd0);
    wb_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      probe(P_BUSY, 64'd1);
    end
    soft_rst_status = 1'b0;

    // same divider: start one cycle after the grant
    send(0, 6'd0, 32'd0, 8'd255, 1, g);
    tick();
    finish_ok(0);

    // divider change: new divider visible after grant, start 17 cycles later
    send(1, 6'd17, 32'hDEADBEEF, 8'd1, 17, g);
    probe(P_DIV, 64'd1);
    go_to(g + 20);
    finish_ok(1);

    // contention: grants alternate starting with requester 0
    req_cmd0 = 6'd5; req_arg0 = 32'h1000_0000; req_div0 = 8'd1;
    req_cmd1 = 6'd6; req_arg1 = 32'h2000_0001; req_div1 = 8'd1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      g = cyc;
      id = i % 2;
      expect_ev(K_RDY, g, (id == 0) ? 64'd1 : 64'd2);
      expect_ev(K_START, g + 1, {18'b0, 8'd1, (id == 0) ? 6'd5 : 6'd6,
                                 (id == 0) ? 32'h1000_0000 : 32'h2000_0001});
      tick(); tick();
      finish_ok(id);
    end
    req_valid = 2'b00;

    // timeout: soft reset and response 16 cycles after cmd_start
    send(0, 6'd9, 32'h55, 8'd1, 1, g);
    s = g + 1;
    expect_ev(K_SRST, s + 16, 64'd1);
    expect_ev(K_RSP, s + 16, 64'({1'b0, SDC_RSP_TIMEOUT}));
    go_to(s + 18);
    probe(P_BUSY, 64'd1);
    go_to(s + 22);
    probe(P_BUSY, 64'd1);
    sd_reset_cycle();
    probe(P_DIV, 64'd1);

    // abort in WAIT_DONE wins over a same-cycle completion
    send(1, 6'd12, 32'hA5A5, 8'd1, 1, g);
    tick();
    abort = 1'b1;
    done_tgl = ~done_tgl;
    expect_ev(K_SRST, cyc + 1, 64'd1);
    expect_ev(K_RSP, cyc + 1, 64'({1'b1, SDC_RSP_ABORT}));
    tick();
    abort = 1'b0;
    go_to(g + 7);
    probe(P_BUSY, 64'd1);
    probe(P_IDX, 64'd12);
    sd_reset_cycle();

    // abort in IDLE with a pending request: no grant, no response
    wait_idle();
    req_cmd0 = 6'd3; req_arg0 = 32'd7; req_div0 = 8'd1;
    req_valid = 2'b01;
    abort = 1'b1;
    expect_ev(K_SRST, cyc + 1, 64'd1);
    tick();
    abort = 1'b0;
    req_valid = 2'b00;
    tick();
    probe(P_BUSY, 64'd1);
    sd_reset_cycle();
    send(0, 6'd3, 32'd7, 8'd1, 1, g);
    tick();
    finish_ok(0);

    // wb_rst during divider settle: no start, no response, reset values return
    send(1, 6'd20, 32'h33, 8'd200, -1, g);
    probe(P_DIV, 64'd200);
    go_to(g + 5);
    wb_rst = 1'b1;
    tick();
    probe(P_DIV, 64'd255); probe(P_IDX, 64'd0); probe(P_ARG, 64'd0); probe(P_BUSY, 64'd1);
    tick();
    wb_rst = 1'b0;
    go_to(g + 30);
    send(1, 6'd21, 32'h44, 8'd1, 17, g);
    go_to(g + 19);
    finish_ok(1);
    tick(); tick();
    end_req = 1'b1;
  end

endmodule
